// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the width of the time-shared adder slice.
package nibble_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_seq_rip_add.sv
// Purely combinational 4-bit ripple-carry adder built from full-adder cells.
module rip_add
    import nibble_add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic                Cout,
    output logic [NIBBLE_W-1:0] Sum
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = Cin;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_full_adder
        assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
        assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end

    assign Cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_add_seq.sv
// Wide add/subtract unit that reuses one 4-bit ripple adder over NIBBLES
// cycles, least-significant nibble first, behind valid/ready handshakes.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NIBBLES - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   k_reg, k_next;
    logic [W-1:0]    a_reg, a_next;
    logic [W-1:0]    b_reg, b_next;
    logic [W-1:0]    acc_reg, acc_next;
    logic            carry_reg, carry_next;
    logic            msb_a_reg, msb_a_next;
    logic            msb_b_reg, msb_b_next;
    logic [W-1:0]    sum_reg, sum_next;
    logic            cout_reg, cout_next;
    logic            ovf_reg, ovf_next;

    logic [W-1:0]          b_in;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic                  nib_cout;
    logic [W-1:0]          nib_ext;

    assign b_in    = sub ? ~b : b;
    assign nib_ext = W'(nib_sum);

    rip_add u_rip_add (
        .A    (a_reg[NIBBLE_W-1:0]),
        .B    (b_reg[NIBBLE_W-1:0]),
        .Cin  (carry_reg),
        .Cout (nib_cout),
        .Sum  (nib_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            msb_a_reg <= 1'b0;
            msb_b_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            msb_a_reg <= msb_a_next;
            msb_b_reg <= msb_b_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        msb_a_next = msb_a_reg;
        msb_b_next = msb_b_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b_in;
                    carry_next = sub | cin;
                    msb_a_next = a[W-1];
                    msb_b_next = b_in[W-1];
                    acc_next   = '0;
                    k_next     = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // New nibble enters at the top so nibble 0 lands in [3:0] after NIBBLES shifts.
                a_next     = a_reg >> NIBBLE_W;
                b_next     = b_reg >> NIBBLE_W;
                acc_next   = (acc_reg >> NIBBLE_W) | (nib_ext << (W - NIBBLE_W));
                carry_next = nib_cout;
                k_next     = k_reg + 1'b1;
                if (k_reg == K_LAST) begin
                    k_next     = '0;
                    state_next = ST_DONE;
                    sum_next   = acc_next;
                    cout_next  = nib_cout;
                    ovf_next   = (msb_a_reg == msb_b_reg) && (acc_next[W-1] != msb_a_reg);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs read as zero during any reset cycle, not just after the reset edge.
    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_DONE) && !rst;
    assign sum       = rst ? '0 : sum_reg;
    assign cout      = rst ? 1'b0 : cout_reg;
    assign ovf       = rst ? 1'b0 : ovf_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4): directed vector table,
// handshake/reset corner sequences and randomized operations against a model.
module tb_nibble_add_seq;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    nibble_add_seq #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as unsigned and signed values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] s, output logic c, output logic o);
        int unsigned ua, ub, ur;
        int sa, sb, r;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            r  = sa - sb;
        end else begin
            ur = ua + ub + int'(mcin);
            c  = (ur > 32'd65535);
            r  = sa + sb + int'(mcin);
        end
        s = ur[W-1:0];
        o = (r > 32767) || (r < -32768);
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic tcin, input logic tsub, input int hold,
                          output logic [W-1:0] rs, output logic rc, output logic ro);
        int cyc;
        bit got;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_ready", in_ready, 1);
        a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if (out_valid) got = 1;
        end
        check("latency", cyc, NIB + 1);
        rs = sum; rc = cout; ro = ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_sum", sum, rs);
            check("hold_cout", cout, rc);
            check("hold_ovf", ovf, ro);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_ready", in_ready, 1);
        check("post_valid", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] rs, es;
        logic         rc, ro, ec, eo;
        logic [W-1:0] ra, rb;
        logic         rcin, rsub;
        bit           seen;

        vecs[0] = '{a:16'h1234, b:16'h4321, cin:0, sub:0, s:16'h5555, c:0, o:0};
        vecs[1] = '{a:16'hFFFF, b:16'h0001, cin:0, sub:0, s:16'h0000, c:1, o:0};
        vecs[2] = '{a:16'h7FFF, b:16'h0001, cin:0, sub:0, s:16'h8000, c:0, o:1};
        vecs[3] = '{a:16'h8000, b:16'hFFFF, cin:0, sub:0, s:16'h7FFF, c:1, o:1};
        vecs[4] = '{a:16'h0005, b:16'h0007, cin:1, sub:1, s:16'hFFFE, c:0, o:0};
        vecs[5] = '{a:16'h0007, b:16'h0005, cin:0, sub:1, s:16'h0002, c:1, o:0};
        vecs[6] = '{a:16'h0000, b:16'h0000, cin:1, sub:0, s:16'h0001, c:0, o:0};
        vecs[7] = '{a:16'h8000, b:16'h0001, cin:0, sub:1, s:16'h7FFF, c:1, o:1};

        // Reset state, sampled while rst is still high.
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", in_ready, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, rs, rc, ro);
            $display("vec %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro);
            check("vec_sum", rs, vecs[i].s);
            check("vec_cout", rc, vecs[i].c);
            check("vec_ovf", ro, vecs[i].o);
        end

        // Backpressure: result held for 3 cycles while in_valid/a/b toggle.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3, rs, rc, ro);
        $display("backpressure: sum=%h cout=%0d ovf=%0d", rs, rc, ro);
        check("bp_sum", rs, 16'h5555);
        @(negedge clk);
        check("bp_no_accept", in_ready, 1);
        check("bp_no_valid", out_valid, 0);

        // Reset in the middle of RUN aborts the operation.
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_ready", in_ready, 0);
        check("midrun_rst_valid", out_valid, 0);
        check("midrun_rst_sum", sum, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_after_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrun_no_valid", seen, 0);
        $display("reset mid-run: aborted op 1111+2222");
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
        $display("after abort: sum=%h", rs);
        check("after_abort_sum", rs, 16'h0002);

        // Simultaneous rst and in_valid: nothing accepted.
        a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1;
        end
        check("rst_wins_no_accept", seen, 0);
        $display("rst+in_valid: no accept");

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            rcin = 1'($urandom); rsub = 1'($urandom);
            if (n % 5 == 0) rb = ra;
            model(ra, rb, rcin, rsub, es, ec, eo);
            run_op(ra, rb, rcin, rsub, n % 3, rs, rc, ro);
            $display("rand %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                     n, ra, rb, rcin, rsub, rs, rc, ro);
            check("rand_sum", rs, es);
            check("rand_cout", rc, ec);
            check("rand_ovf", ro, eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequential wide-operand adder/subtractor that time-shares a single 4-bit ripple-carry adder over NIBBLES cycles. It is a multi-cycle arithmetic unit behind a valid/ready handshake. Each accepted operand pair is processed least-significant nibble first, with the carry registered between nibbles. The result is presented until the consumer takes it.

## Interface
- NIBBLES, default 4: operand width in nibbles, W = 4*NIBBLES; legal range 1..16.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A, unsigned or two's complement.
- b  in  W  operand B.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 selects A - B, computed as A + ~B + 1.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- sum  out  W  result, modulo 2^W.
- cout  out  1  carry out of bit W-1; for sub, 1 means no borrow.
- ovf  out  1  signed overflow.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: NIBBLES cycles, counter k = 0..NIBBLES-1.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE when k reaches NIBBLES-1.
  - DONE -> IDLE on out_ready.
- On accept, capture the following:
  - a_q = a.
  - b_q = sub ? ~b : b.
  - carry_q = sub ? 1 : cin.
  - msb_a = a[W-1].
  - msb_b = b_q[W-1], i.e. after any inversion.
  - k = 0.
- RUN cycle k:
  - Adder inputs: a_q[3:0], b_q[3:0], carry_q.
  - Nibble sum shifts into the top of sum_q; a_q and b_q shift right by 4.
  - carry_q takes the adder carry-out.
- Entering DONE:
  - sum holds the full result with nibble 0 in bits [3:0].
  - cout = final carry_q.
  - ovf = (msb_a == msb_b) & (sum[W-1] != msb_a).
- Outputs are registered and held stable throughout DONE regardless of any input, including in_valid.
- in_valid is ignored outside IDLE. Operands do not need to be held after acceptance.
- Width rules:
  - Counter width is clog2(NIBBLES), minimum 1.
  - All arithmetic is modulo 2^W; no sign extension anywhere.

## Timing
- Accept edge is cycle 0. Nibble k is computed in cycle k+1. out_valid rises at the edge ending cycle NIBBLES, so it is high in cycle NIBBLES+1.
- Latency from accept to out_valid is NIBBLES+1 cycles.
- Result transfers on the first edge where out_valid & out_ready; in_ready is high the next cycle.
- Minimum occupancy is NIBBLES+2 cycles per operation; no overlap of operations.
- Reset values:
  - During any cycle with rst=1: in_ready=0, out_valid=0, sum=0, cout=0, ovf=0, state IDLE, counter 0.
  - First cycle after rst falls: in_ready=1.
- Reset in RUN or DONE aborts the operation: no out_valid for it, partial sum is discarded, and outputs are zeroed.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.
- NIBBLES=1: RUN lasts exactly one cycle; latency is 2.

## Structure
- The shared arithmetic package holds:
  - the state encoding (IDLE, RUN, DONE) as a 2-bit enum typedef;
  - the NIBBLE_W = 4 constant.
- One sub-module instance: the 4-bit ripple-carry adder rip_add. It is built from full_adder cells and is purely combinational, with ports A, B, Cin, Cout, Sum.
- Everything else (FSM, shift registers, counter, flags) lives in nibble_add_seq; no other sub-modules.

## Test plan
All scenarios use NIBBLES=4.
- Plain add, 0x1234 + 0x4321, cin=0: out_valid 5 cycles after accept; sum=0x5555, cout=0, ovf=0.
- Full carry ripple, 0xFFFF + 0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Checks that carry propagates across all nibble boundaries.
- Signed overflow, 0x7FFF + 0x0001: sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0xFFFF gives sum=0x7FFF, cout=1, ovf=1.
- Subtract, sub=1, 0x0005 - 0x0007, with cin=1 to prove cin is ignored: sum=0xFFFE, cout=0, ovf=0. Also 0x0007 - 0x0005 gives sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while toggling in_valid and a/b. Required: sum/cout/ovf stable, in_ready=0, no new accept. Raise out_ready, and in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst for 1 cycle at cycle 2 after accepting 0x1111 + 0x2222. Required: out_valid never rises for that op, outputs are 0, in_ready=1 the cycle after rst falls. The next op 0x0001 + 0x0001 gives 0x0002.
